// File: rtl/vec_mag_iter.sv
// vec_mag_iter: iterative vector magnitude / sum-of-squares unit.
//
// Accepts an unsigned operand pair (x, y) and computes either
// floor(sqrt(x^2 + y^2)) (mode 0) or x^2 + y^2 (mode 1). The squares are
// built by shift-add over W cycles. The magnitude then takes W+1 cycles of
// restoring square root, one root bit per cycle, MSB first.
//
// Timing, counting the accept edge as cycle 1:
//   - mode 0: done rises on cycle 2W+2;
//   - mode 1: done rises on cycle W+1.
//
// Ports:
//   clk     - clock, rising edge active
//   rst     - synchronous active-high reset, overrides ena and start
//   ena     - clock enable; 0 freezes all registers
//   start   - request a computation (only honoured in IDLE)
//   mode    - 0 = magnitude, 1 = sum of squares
//   x, y    - unsigned W-bit operands
//   busy    - high while squaring or taking the root
//   done    - one-cycle completion strobe (stretched while ena=0)
//   result  - 2W+1-bit result, held until the next completion
//   exact   - mode 0: remainder was zero; mode 1: always 1
module vec_mag_iter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [2*W:0] result,
    output logic         exact
);

    // Counter must reach W (last root step), so it needs to hold W+1 values.
    localparam int unsigned CW = $clog2(W + 2);

    typedef enum logic [1:0] {StIdle, StSquare, StSqrt, StDone} state_e;

    state_e state_q, state_d;

    logic           mode_q,   mode_d;
    logic [2*W-1:0] mx_q,     mx_d;      // x multiplicand, shifted left per step
    logic [2*W-1:0] my_q,     my_d;      // y multiplicand, shifted left per step
    logic [W-1:0]   bx_q,     bx_d;      // x multiplier bits, shifted right per step
    logic [W-1:0]   by_q,     by_d;      // y multiplier bits, shifted right per step
    logic [2*W+1:0] acc_q,    acc_d;     // sum of squares, then root radicand shifter
    logic [W+1:0]   rem_q,    rem_d;     // partial remainder, never exceeds 2*root
    logic [W:0]     root_q,   root_d;
    logic [CW-1:0]  cnt_q,    cnt_d;
    logic [2*W:0]   result_q, result_d;
    logic           exact_q,  exact_d;

    logic [2*W+1:0] sq_step;
    logic [W+3:0]   rem_sh;
    logic [W+3:0]   trial;
    logic [W+3:0]   rem_next;
    logic           root_bit;
    logic [W:0]     root_next;
    logic           sq_last;
    logic           sqrt_last;

    // ------------------------------------------------------------------
    // Arithmetic step logic
    // ------------------------------------------------------------------
    always_comb begin
        // One shift-add step for both squares at once. Two W-bit squares
        // sum to less than 2^(2W+1), so the extra top bit of acc stays 0.
        sq_step = acc_q;
        if (bx_q[0]) begin
            sq_step = sq_step + {2'b00, mx_q};
        end
        if (by_q[0]) begin
            sq_step = sq_step + {2'b00, my_q};
        end

        // Restoring root step: bring down the next bit pair and try to
        // subtract (4*root + 1).
        rem_sh    = {rem_q, acc_q[2*W+1 -: 2]};
        trial     = {1'b0, root_q, 2'b01};
        root_bit  = (rem_sh >= trial);
        rem_next  = root_bit ? (rem_sh - trial) : rem_sh;
        root_next = {root_q[W-1:0], root_bit};

        sq_last   = (cnt_q == CW'(W - 1));
        sqrt_last = (cnt_q == CW'(W));
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSquare;
                end
            end
            StSquare: begin
                if (sq_last) begin
                    state_d = mode_q ? StDone : StSqrt;
                end
            end
            StSqrt: begin
                if (sqrt_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy   = (state_q == StSquare) || (state_q == StSqrt);
        done   = (state_q == StDone);
        result = result_q;
        exact  = exact_q;
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        mode_d   = mode_q;
        mx_d     = mx_q;
        my_d     = my_q;
        bx_d     = bx_q;
        by_d     = by_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        root_d   = root_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exact_d  = exact_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d = mode;
                    mx_d   = {{W{1'b0}}, x};
                    my_d   = {{W{1'b0}}, y};
                    bx_d   = x;
                    by_d   = y;
                    acc_d  = '0;
                    rem_d  = '0;
                    root_d = '0;
                    cnt_d  = '0;
                end
            end
            StSquare: begin
                acc_d = sq_step;
                mx_d  = mx_q << 1;
                my_d  = my_q << 1;
                bx_d  = bx_q >> 1;
                by_d  = by_q >> 1;
                if (sq_last) begin
                    cnt_d = '0;
                    if (mode_q) begin
                        result_d = sq_step[2*W:0];
                        exact_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSqrt: begin
                acc_d  = acc_q << 2;
                rem_d  = rem_next[W+1:0];
                root_d = root_next;
                cnt_d  = cnt_q + 1'b1;
                if (sqrt_last) begin
                    result_d = {{W{1'b0}}, root_next};
                    exact_d  = (rem_next == '0);
                end
            end
            StDone: begin
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= 1'b0;
            mx_q     <= '0;
            my_q     <= '0;
            bx_q     <= '0;
            by_q     <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            exact_q  <= 1'b0;
        end else if (ena) begin
            mode_q   <= mode_d;
            mx_q     <= mx_d;
            my_q     <= my_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            root_q   <= root_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exact_q  <= exact_d;
        end
    end

endmodule

// File: tb/tb_vec_mag_iter.sv
// Testbench for vec_mag_iter: three instances (W=4, 8, 12) share clock and
// control; directed cases run on the W=8 instance, random operand pairs on
// all three against an integer reference model.
module tb_vec_mag_iter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ena = 1'b1;
    logic start = 1'b0;
    logic mode = 1'b0;

    logic [3:0]  x4 = '0, y4 = '0;
    logic [7:0]  x8 = '0, y8 = '0;
    logic [11:0] x12 = '0, y12 = '0;
    logic        busy4, busy8, busy12;
    logic        done4, done8, done12;
    logic        exact4, exact8, exact12;
    logic [8:0]  res4;
    logic [16:0] res8;
    logic [24:0] res12;

    int checks = 0;
    int failures = 0;
    int last_busy8 = 0;

    always #5 clk = ~clk;

    vec_mag_iter #(.W(4)) u_dut4 (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .mode(mode),
        .x(x4), .y(y4), .busy(busy4), .done(done4), .result(res4), .exact(exact4)
    );

    vec_mag_iter #(.W(8)) u_dut8 (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .mode(mode),
        .x(x8), .y(y8), .busy(busy8), .done(done8), .result(res8), .exact(exact8)
    );

    vec_mag_iter #(.W(12)) u_dut12 (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .mode(mode),
        .x(x12), .y(y12), .busy(busy12), .done(done12), .result(res12), .exact(exact12)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reference: plain integer arithmetic on the masked operands.
    function automatic void model(input int w, input bit m, input longint xv,
                                  input longint yv, output longint r, output bit ex);
        longint xm, ym, s;
        xm = xv & ((64'd1 << w) - 1);
        ym = yv & ((64'd1 << w) - 1);
        s  = xm * xm + ym * ym;
        if (m) begin
            r  = s;
            ex = 1'b1;
        end else begin
            r = longint'($floor($sqrt(real'(s))));
            while (r * r > s) r--;
            while ((r + 1) * (r + 1) <= s) r++;
            ex = (r * r == s);
        end
    endfunction

    // Start one operation on all instances, wait for every done, check
    // latency (accept edge counted as cycle 1), result, exact and the
    // single-cycle done. Returns with all instances back in IDLE.
    task automatic run_op(input bit m, input int xv, input int yv);
        longint r[3];
        bit     ex[3];
        int     lat[3];
        int     wv[3];
        int     n;
        wv = '{4, 8, 12};
        for (int i = 0; i < 3; i++) begin
            model(wv[i], m, longint'(xv), longint'(yv), r[i], ex[i]);
            lat[i] = 0;
        end
        start = 1'b1;
        mode  = m;
        x4 = xv[3:0];   y4 = yv[3:0];
        x8 = xv[7:0];   y8 = yv[7:0];
        x12 = xv[11:0]; y12 = yv[11:0];
        tick();
        start = 1'b0;
        check("accept_busy", busy8, 1);
        n = 1;
        last_busy8 = busy8 ? 1 : 0;
        while ((lat[0] == 0 || lat[1] == 0 || lat[2] == 0) && n < 200) begin
            tick();
            n++;
            if (busy8) last_busy8++;
            if (done4 && lat[0] == 0) lat[0] = n;
            if (done8 && lat[1] == 0) lat[1] = n;
            if (done12 && lat[2] == 0) lat[2] = n;
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("latency_w%0d", wv[i]), lat[i], m ? wv[i] + 1 : 2 * wv[i] + 2);
        end
        check("result_w4", res4, r[0]);
        check("exact_w4", exact4, ex[0]);
        check("result_w8", res8, r[1]);
        check("exact_w8", exact8, ex[1]);
        check("result_w12", res12, r[2]);
        check("exact_w12", exact12, ex[2]);
        tick();
        check("done_single_cycle", {done4, done8, done12}, 0);
    endtask

    initial begin
        int n, lat, pulses, xv, yv;
        bit m;

        // Reset state
        do_reset();
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_result", res8, 0);
        check("rst_exact", exact8, 0);

        // Classic 3-4-5 triangle, including busy duration
        run_op(1'b0, 3, 4);
        check("345_busy_cycles", last_busy8, 17);

        // Largest operands, both modes
        run_op(1'b0, 255, 255);
        run_op(1'b1, 255, 255);

        // Zero and non-perfect-square minimum
        run_op(1'b0, 0, 0);
        run_op(1'b0, 1, 1);

        // Start/operand toggling while busy and a 5-cycle ena drop mid-root
        start = 1'b1; mode = 1'b0; x8 = 8'd6; y8 = 8'd8;
        tick();
        start = 1'b0;
        n = 1; lat = 0; pulses = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            n++;
            if (done8) begin
                pulses++;
                if (lat == 0) lat = n;
            end
            if (n == 11) ena = 1'b0;
            if (n == 16) ena = 1'b1;
            start = busy8 ? 1'($urandom_range(0, 1)) : 1'b0;
            x8 = 8'($urandom);
            y8 = 8'($urandom);
        end
        check("toggle_done_pulses", pulses, 1);
        check("toggle_latency", lat, 23);
        check("toggle_result", res8, 10);
        check("toggle_exact", exact8, 1);
        start = 1'b0;
        do_reset();

        // Reset mid-SQUARE aborts the operation
        run_op(1'b0, 5, 5);
        start = 1'b1; mode = 1'b0; x8 = 8'd3; y8 = 8'd4;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_result", res8, 0);
        check("abort_exact", exact8, 0);
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (done4 || done8 || done12) pulses++;
        end
        check("abort_no_done", pulses, 0);
        run_op(1'b0, 5, 12);

        // Random regression, back-to-back starts, operand corners mixed in
        for (int k = 0; k < 1500; k++) begin
            m = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: xv = 0;
                1: xv = 32'hffff;
                default: xv = int'($urandom & 32'hffff);
            endcase
            case ($urandom_range(0, 7))
                0: yv = 0;
                1: yv = 32'hffff;
                default: yv = int'($urandom & 32'hffff);
            endcase
            run_op(m, xv, yv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
